// File: rtl/mc_memory_responder.sv
// mc_memory_responder: 1-cycle-latency RAM responder with post-reset clear, sticky error flags and access counters; RAW_FORWARD_EN selects write-first same-address reads.
module mc_memory_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0] read_data,
  input  logic                  write_enable,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  init_done,
  output logic [1:0]            err,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(DEPTH);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_n;
  logic [IW-1:0] clr_idx, clr_idx_n;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic run, wr_req, rd_in, wr_in, rd_ok, wr_ok, raw_hit;
  logic [IW-1:0] ra, wa;
  assign run       = state == RUN;
  assign init_done = run;
  assign wr_req    = write_enable & enable;
  assign rd_in     = read_address < LIMIT;
  assign wr_in     = write_address < LIMIT;
  assign ra        = read_address[IW-1:0];
  assign wa        = write_address[IW-1:0];
  assign rd_ok     = run & read_enable & rd_in;
  assign wr_ok     = run & wr_req & wr_in;
`ifdef RAW_FORWARD_EN
  assign raw_hit   = rd_ok & wr_ok & (ra == wa);
`else
  assign raw_hit   = 1'b0;
`endif
  always_comb begin
    state_n   = (!run && clr_idx == LAST) ? RUN : state;
    clr_idx_n = run ? clr_idx : clr_idx + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      clr_idx <= '0;
    end else begin
      state   <= state_n;
      clr_idx <= clr_idx_n;
    end
  end
  // RAM port: clearing owns it during INIT, accepted writes during RUN; nothing lands in a reset cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) mem[clr_idx] <= '0;
      else if (wr_ok) mem[wa] <= write_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= '0;
      err       <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      read_data <= !read_enable ? read_data : !rd_ok ? '0 : raw_hit ? write_data : mem[ra];
      err[0]    <= err[0] | (read_enable & ~rd_in) | (wr_req & ~wr_in);
      err[1]    <= err[1] | (~run & (read_enable | wr_req));
      rd_count  <= rd_count + 32'(rd_ok && rd_count != '1);
      wr_count  <= wr_count + 32'(wr_ok && wr_count != '1);
    end
  end
endmodule
